// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, taken-branch squash and data-memory wait
// handling, with a memory-wait timeout and saturating stall/flush statistics.
module hazard_ctrl #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_reg1_addr,
    input  logic [REG_ADDR_W-1:0] id_reg2_addr,
    input  logic                  id_reg1_read,
    input  logic                  id_reg2_read,
    input  logic [REG_ADDR_W-1:0] exe_write_addr,
    input  logic                  exe_reg_write,
    input  logic                  exe_DM_read,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  dm_ready,
    input  logic                  cnt_clr,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_exe_stall,
    output logic                  exe_mem_stall,
    output logic                  mem_wb_bubble,
    output logic                  id_exe_bubble,
    output logic                  if_id_flush,
    output logic                  mem_timeout_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_ERR      = 2'd2;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              err_nxt;
    logic              freeze;
    logic              load_use;
    logic              reg1_hit;
    logic              reg2_hit;

    assign freeze   = mem_req & ~dm_ready;
    assign reg1_hit = id_reg1_read & (id_reg1_addr == exe_write_addr);
    assign reg2_hit = id_reg2_read & (id_reg2_addr == exe_write_addr);
    assign load_use = exe_DM_read & exe_reg_write & (reg1_hit | reg2_hit);

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_RUN;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            state           <= state_nxt;
            wait_cnt        <= wait_nxt;
            mem_timeout_err <= err_nxt;
        end
    end

    // Next-state: track consecutive memory-wait cycles, trap into ERR on timeout
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        err_nxt   = mem_timeout_err;
        case (state)
            S_RUN: begin
                if (freeze) begin
                    state_nxt = S_MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                if (!freeze) begin
                    state_nxt = S_RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_ERR;
                    err_nxt   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_ERR: begin
                err_nxt = 1'b1;
            end
            default: begin
                state_nxt = S_RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // Zero-latency pipeline controls; reset forces them low immediately
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_exe_stall  = 1'b0;
        exe_mem_stall = 1'b0;
        mem_wb_bubble = 1'b0;
        id_exe_bubble = 1'b0;
        if_id_flush   = 1'b0;
        if (!rst) begin
            if (state == S_ERR || freeze) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_exe_stall  = 1'b1;
                exe_mem_stall = 1'b1;
                mem_wb_bubble = 1'b1;
            end else if (branch_taken) begin
                // consumer of any load is squashed, so load-use is moot
                if_id_flush   = 1'b1;
                id_exe_bubble = 1'b1;
            end else if (load_use) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_exe_bubble = 1'b1;
            end
        end
    end

    // Saturating statistics; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (CNT_W=4, MEM_TIMEOUT=4) using an
// expected-control queue filled as stimulus is applied.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_reg1_addr;
    logic [4:0] id_reg2_addr;
    logic       id_reg1_read;
    logic       id_reg2_read;
    logic [4:0] exe_write_addr;
    logic       exe_reg_write;
    logic       exe_DM_read;
    logic       branch_taken;
    logic       mem_req;
    logic       dm_ready;
    logic       cnt_clr;
    logic       pc_stall;
    logic       if_id_stall;
    logic       id_exe_stall;
    logic       exe_mem_stall;
    logic       mem_wb_bubble;
    logic       id_exe_bubble;
    logic       if_id_flush;
    logic       mem_timeout_err;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    // {pc, if_id, id_exe, exe_mem stalls, mem_wb_bubble, id_exe_bubble, if_id_flush}
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_FREEZE = 7'b1111100;
    localparam logic [6:0] C_BR     = 7'b0000011;
    localparam logic [6:0] C_LU     = 7'b1100010;

    logic [6:0] ctrl;
    logic [6:0] exp_q[$];
    logic [6:0] exp;
    int         total = 0;
    int         bad   = 0;

    assign ctrl = {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall,
                   mem_wb_bubble, id_exe_bubble, if_id_flush};

    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
        .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read),
        .exe_write_addr(exe_write_addr), .exe_reg_write(exe_reg_write),
        .exe_DM_read(exe_DM_read), .branch_taken(branch_taken),
        .mem_req(mem_req), .dm_ready(dm_ready), .cnt_clr(cnt_clr),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_exe_stall(id_exe_stall), .exe_mem_stall(exe_mem_stall),
        .mem_wb_bubble(mem_wb_bubble), .id_exe_bubble(id_exe_bubble),
        .if_id_flush(if_id_flush), .mem_timeout_err(mem_timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        id_reg1_addr = 5'd0; id_reg2_addr = 5'd0;
        id_reg1_read = 1'b0; id_reg2_read = 1'b0;
        exe_write_addr = 5'd0; exe_reg_write = 1'b0; exe_DM_read = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; dm_ready = 1'b0; cnt_clr = 1'b0;
    endtask

    // load of x<a> in EXE, ID reading x<a> on source 1
    task automatic set_lu(input logic [4:0] a);
        exe_DM_read = 1'b1; exe_reg_write = 1'b1; exe_write_addr = a;
        id_reg1_addr = a; id_reg1_read = 1'b1;
    endtask

    // inputs change 1 time unit after the rising edge, outputs sampled 3 later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        mem_req = 1'b1;
        exp_q.push_back(C_NONE);
        #2;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL reset_ctrl got=%b want=%b", ctrl, exp); end
        total++;
        if ({mem_timeout_err, stall_cnt, flush_cnt} !== 9'd0) begin
            bad++; $display("FAIL reset_regs got=%b want=0", {mem_timeout_err, stall_cnt, flush_cnt});
        end
        idle();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        set_lu(5'd3);
        exp_q.push_back(C_LU); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL lu_reg1 got=%b want=%b", ctrl, exp); end
        tick();
        exe_DM_read = 1'b0;
        exp_q.push_back(C_NONE); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL lu_gone got=%b want=%b", ctrl, exp); end
        total++;
        if (stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", stall_cnt); end
        tick();
        set_lu(5'd3); id_reg1_addr = 5'd5; id_reg2_addr = 5'd3; id_reg2_read = 1'b1;
        exp_q.push_back(C_LU); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL lu_reg2 got=%b want=%b", ctrl, exp); end
        tick();
        id_reg2_read = 1'b0;
        exp_q.push_back(C_NONE); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL lu_reg2_noread got=%b want=%b", ctrl, exp); end
        total++;
        if (stall_cnt !== 4'd2) begin bad++; $display("FAIL lu_cnt2 got=%0d want=2", stall_cnt); end
        tick();
        set_lu(5'd3); exe_reg_write = 1'b0;
        exp_q.push_back(C_NONE); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL lu_nowrite got=%b want=%b", ctrl, exp); end
        tick();
        idle(); set_lu(5'd0);
        exp_q.push_back(C_LU); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL lu_r0 got=%b want=%b", ctrl, exp); end
        tick();
        idle();
    endtask

    task automatic test_branch();
        set_lu(5'd3); branch_taken = 1'b1;
        exp_q.push_back(C_BR); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL br_over_lu got=%b want=%b", ctrl, exp); end
        tick();
        idle();
        exp_q.push_back(C_NONE); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL br_after got=%b want=%b", ctrl, exp); end
        total++;
        if ({stall_cnt, flush_cnt} !== {4'd3, 4'd1}) begin
            bad++; $display("FAIL br_cnts got=%0d/%0d want=3/1", stall_cnt, flush_cnt);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        mem_req = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(C_FREEZE); #3;
            exp = exp_q.pop_front(); total++;
            if (ctrl !== exp) begin bad++; $display("FAIL wait_br%0d got=%b want=%b", i, ctrl, exp); end
            tick();
        end
        dm_ready = 1'b1;
        exp_q.push_back(C_BR); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL wait_release_br got=%b want=%b", ctrl, exp); end
        tick();
        idle(); set_lu(5'd7); mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(C_FREEZE); #3;
            exp = exp_q.pop_front(); total++;
            if (ctrl !== exp) begin bad++; $display("FAIL wait_lu%0d got=%b want=%b", i, ctrl, exp); end
            tick();
        end
        dm_ready = 1'b1;
        exp_q.push_back(C_LU); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL wait_release_lu got=%b want=%b", ctrl, exp); end
        tick();
        idle();
        exp_q.push_back(C_NONE); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL wait_idle got=%b want=%b", ctrl, exp); end
        total++;
        if ({mem_timeout_err, stall_cnt, flush_cnt} !== {1'b0, 4'd10, 4'd2}) begin
            bad++; $display("FAIL wait_cnts got=%0d/%0d/%0d want=0/10/2", mem_timeout_err, stall_cnt, flush_cnt);
        end
        tick();
    endtask

    task automatic test_same_cycle_ready();
        set_lu(5'd9); mem_req = 1'b1; dm_ready = 1'b1;
        exp_q.push_back(C_LU); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL ready_lu got=%b want=%b", ctrl, exp); end
        tick();
        idle(); mem_req = 1'b1; dm_ready = 1'b1;
        exp_q.push_back(C_NONE); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL ready_nostall got=%b want=%b", ctrl, exp); end
        total++;
        if (stall_cnt !== 4'd11) begin bad++; $display("FAIL ready_cnt got=%0d want=11", stall_cnt); end
        tick();
        idle();
    endtask

    task automatic test_saturation();
        set_lu(5'd4);
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(C_LU); #3;
            exp = exp_q.pop_front(); total++;
            if (ctrl !== exp) begin bad++; $display("FAIL sat_lu%0d got=%b want=%b", i, ctrl, exp); end
            tick();
        end
        total++;
        if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt got=%0d want=15", stall_cnt); end
        cnt_clr = 1'b1;
        exp_q.push_back(C_LU); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL clr_lu got=%b want=%b", ctrl, exp); end
        tick();
        idle();
        #3; total++;
        if ({stall_cnt, flush_cnt} !== 8'd0) begin
            bad++; $display("FAIL clr_cnts got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
        end
        tick();
    endtask

    task automatic test_timeout();
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(C_FREEZE); #3;
            exp = exp_q.pop_front(); total++;
            if (ctrl !== exp || mem_timeout_err !== 1'b0) begin
                bad++; $display("FAIL to_wait%0d got=%b/%b want=%b/0", i, ctrl, mem_timeout_err, exp);
            end
            tick();
        end
        // ERR holds all stalls even with the access gone and a branch pending
        idle(); branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(C_FREEZE); #3;
            exp = exp_q.pop_front(); total++;
            if (ctrl !== exp) begin bad++; $display("FAIL err_ctrl%0d got=%b want=%b", i, ctrl, exp); end
            total++;
            if ({mem_timeout_err, stall_cnt, flush_cnt} !== {1'b1, 4'(4 + i), 4'd0}) begin
                bad++; $display("FAIL err_regs%0d got=%0d/%0d/%0d want=1/%0d/0",
                                i, mem_timeout_err, stall_cnt, flush_cnt, 4 + i);
            end
            tick();
        end
        #1;
        rst = 1'b1; mem_req = 1'b1; dm_ready = 1'b0;
        exp_q.push_back(C_NONE); #1;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL rst_err_ctrl got=%b want=%b", ctrl, exp); end
        total++;
        if ({mem_timeout_err, stall_cnt, flush_cnt} !== 9'd0) begin
            bad++; $display("FAIL rst_err_regs got=%b want=0", {mem_timeout_err, stall_cnt, flush_cnt});
        end
        idle();
        @(negedge clk);
        rst = 1'b0;
        tick();
        branch_taken = 1'b1;
        exp_q.push_back(C_BR); #3;
        exp = exp_q.pop_front(); total++;
        if (ctrl !== exp) begin bad++; $display("FAIL rst_run_br got=%b want=%b", ctrl, exp); end
        tick();
        idle(); #3;
        total++;
        if ({mem_timeout_err, flush_cnt} !== {1'b0, 4'd1}) begin
            bad++; $display("FAIL rst_run_regs got=%0d/%0d want=0/1", mem_timeout_err, flush_cnt);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_same_cycle_ready();
        test_saturation();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
